// File: rtl/alu_reservation_station_pkg.sv
// alu_reservation_station_pkg: shared widths, opcodes, entry layout and CDB capture helper
package alu_reservation_station_pkg;
    localparam int IDWidth       = 32;
    localparam int ROBWidth      = 5;
    localparam int AddressWidth  = 32;
    localparam int InstTypeWidth = 6;
    localparam int RSSizeDefault = 16;

    typedef enum logic [InstTypeWidth-1:0] {
        OP_NOP = 6'd0,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SLL,
        OP_SRL,
        OP_SRA,
        OP_SLT,
        OP_SLTU
    } opcode_e;

    typedef struct packed {
        logic [IDWidth-1:0]  v;
        logic [ROBWidth-1:0] q;
    } operand_t;

    typedef struct packed {
        logic                     valid;
        logic [InstTypeWidth-1:0] opcode;
        logic [IDWidth-1:0]       vj;
        logic [ROBWidth-1:0]      qj;
        logic [IDWidth-1:0]       vk;
        logic [ROBWidth-1:0]      qk;
        logic [IDWidth-1:0]       a;
        logic [AddressWidth-1:0]  pc;
        logic [ROBWidth-1:0]      dest;
    } entry_t;

    // Tag 0 means the value is already present, so it never matches a broadcast
    function automatic operand_t capture(
        input operand_t            op,
        input logic [ROBWidth-1:0] alu_h,
        input logic [IDWidth-1:0]  alu_r,
        input logic [ROBWidth-1:0] lsb_h,
        input logic [IDWidth-1:0]  lsb_r
    );
        operand_t r;
        r = op;
        if (op.q != '0 && op.q == alu_h) r = operand_t'({alu_r, {ROBWidth{1'b0}}});
        else if (op.q != '0 && op.q == lsb_h) r = operand_t'({lsb_r, {ROBWidth{1'b0}}});
        return r;
    endfunction
endpackage

// File: rtl/alu_reservation_station_if.sv
// alu_reservation_station_if: dispatch, CDB, flush/enable and issue bundle of the ALU reservation station
interface alu_reservation_station_if;
    import alu_reservation_station_pkg::*;
    logic                     rdy_in;
    logic                     rob_rs_rst_in;
    logic                     dispatch_en_in;
    logic [InstTypeWidth-1:0] dispatch_opcode_in;
    logic [IDWidth-1:0]       dispatch_vj_in;
    logic [IDWidth-1:0]       dispatch_vk_in;
    logic [ROBWidth-1:0]      dispatch_qj_in;
    logic [ROBWidth-1:0]      dispatch_qk_in;
    logic [IDWidth-1:0]       dispatch_a_in;
    logic [AddressWidth-1:0]  dispatch_pc_in;
    logic [ROBWidth-1:0]      dispatch_dest_in;
    logic                     rs_full_out;
    logic [ROBWidth-1:0]      cdb_alu_h_in;
    logic [ROBWidth-1:0]      cdb_lsb_h_in;
    logic [IDWidth-1:0]       cdb_alu_result_in;
    logic [IDWidth-1:0]       cdb_lsb_result_in;
    logic [InstTypeWidth-1:0] rs_alu_opcode_out;
    logic [IDWidth-1:0]       rs_alu_vj_out;
    logic [IDWidth-1:0]       rs_alu_vk_out;
    logic [IDWidth-1:0]       rs_alu_a_out;
    logic [AddressWidth-1:0]  rs_alu_pc_out;
    logic [ROBWidth-1:0]      rs_alu_dest_out;

    modport master (
        output rdy_in, rob_rs_rst_in, dispatch_en_in, dispatch_opcode_in,
               dispatch_vj_in, dispatch_vk_in, dispatch_qj_in, dispatch_qk_in,
               dispatch_a_in, dispatch_pc_in, dispatch_dest_in,
               cdb_alu_h_in, cdb_lsb_h_in, cdb_alu_result_in, cdb_lsb_result_in,
        input  rs_full_out, rs_alu_opcode_out, rs_alu_vj_out, rs_alu_vk_out,
               rs_alu_a_out, rs_alu_pc_out, rs_alu_dest_out
    );

    modport slave (
        input  rdy_in, rob_rs_rst_in, dispatch_en_in, dispatch_opcode_in,
               dispatch_vj_in, dispatch_vk_in, dispatch_qj_in, dispatch_qk_in,
               dispatch_a_in, dispatch_pc_in, dispatch_dest_in,
               cdb_alu_h_in, cdb_lsb_h_in, cdb_alu_result_in, cdb_lsb_result_in,
        output rs_full_out, rs_alu_opcode_out, rs_alu_vj_out, rs_alu_vk_out,
               rs_alu_a_out, rs_alu_pc_out, rs_alu_dest_out
    );
endinterface

// File: rtl/alu_rs_select.sv
// alu_rs_select: lowest-index priority picker over a request vector
module alu_rs_select #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] req_in,
    output logic         found_out,
    output logic [W-1:0] idx_out
);
    // Scan from the top so the lowest set bit is the last one written
    always_comb begin
        found_out = |req_in;
        idx_out   = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req_in[i]) idx_out = W'(i);
    end
endmodule

// File: rtl/alu_reservation_station.sv
// alu_reservation_station: ALU reservation station with CDB wakeup and lowest-index issue.
// Define ALU_RS_WAKEUP_BYPASS_EN to let an entry issue in the same cycle its last operand arrives on a CDB.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int RS_SIZE  = RSSizeDefault,
    parameter int RS_IDX_W = 4
) (
    input logic                      clk_in,
    input logic                      rst_in,
    alu_reservation_station_if.slave rs_if
);
    entry_t                   entries_q [RS_SIZE];
    entry_t                   entries_d [RS_SIZE];
    entry_t                   woken     [RS_SIZE];
    entry_t                   new_entry;
    logic [RS_SIZE-1:0]       valid_vec;
    logic [RS_SIZE-1:0]       ready_vec;
    logic                     free_found;
    logic                     ready_found;
    logic                     dispatch_ok;
    logic                     issue;
    logic [RS_IDX_W-1:0]      free_idx;
    logic [RS_IDX_W-1:0]      ready_idx;
    logic [InstTypeWidth-1:0] opcode_q, opcode_d;
    logic [IDWidth-1:0]       vj_q, vj_d;
    logic [IDWidth-1:0]       vk_q, vk_d;
    logic [IDWidth-1:0]       a_q, a_d;
    logic [AddressWidth-1:0]  pc_q, pc_d;
    logic [ROBWidth-1:0]      dest_q, dest_d;

    // Apply this cycle's broadcasts to every stored entry and derive readiness
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            woken[i] = entries_q[i];
            {woken[i].vj, woken[i].qj} = capture(operand_t'({entries_q[i].vj, entries_q[i].qj}),
                rs_if.cdb_alu_h_in, rs_if.cdb_alu_result_in, rs_if.cdb_lsb_h_in, rs_if.cdb_lsb_result_in);
            {woken[i].vk, woken[i].qk} = capture(operand_t'({entries_q[i].vk, entries_q[i].qk}),
                rs_if.cdb_alu_h_in, rs_if.cdb_alu_result_in, rs_if.cdb_lsb_h_in, rs_if.cdb_lsb_result_in);
            valid_vec[i] = entries_q[i].valid;
`ifdef ALU_RS_WAKEUP_BYPASS_EN
            ready_vec[i] = woken[i].valid && woken[i].qj == '0 && woken[i].qk == '0;
`else
            ready_vec[i] = entries_q[i].valid && entries_q[i].qj == '0 && entries_q[i].qk == '0;
`endif
        end
    end

    alu_rs_select #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_sel (
        .req_in    (~valid_vec),
        .found_out (free_found),
        .idx_out   (free_idx)
    );

    alu_rs_select #(.N(RS_SIZE), .W(RS_IDX_W)) u_ready_sel (
        .req_in    (ready_vec),
        .found_out (ready_found),
        .idx_out   (ready_idx)
    );

    assign rs_if.rs_full_out = &valid_vec;
    assign dispatch_ok       = rs_if.dispatch_en_in && free_found && !rs_if.rob_rs_rst_in;
    assign issue             = ready_found && !rs_if.rob_rs_rst_in;

    // Build the incoming entry, picking up any operand broadcast in the same cycle
    always_comb begin
        new_entry = '{valid: 1'b1, opcode: rs_if.dispatch_opcode_in,
                      vj: rs_if.dispatch_vj_in, qj: rs_if.dispatch_qj_in,
                      vk: rs_if.dispatch_vk_in, qk: rs_if.dispatch_qk_in,
                      a: rs_if.dispatch_a_in, pc: rs_if.dispatch_pc_in, dest: rs_if.dispatch_dest_in};
        {new_entry.vj, new_entry.qj} = capture(operand_t'({rs_if.dispatch_vj_in, rs_if.dispatch_qj_in}),
            rs_if.cdb_alu_h_in, rs_if.cdb_alu_result_in, rs_if.cdb_lsb_h_in, rs_if.cdb_lsb_result_in);
        {new_entry.vk, new_entry.qk} = capture(operand_t'({rs_if.dispatch_vk_in, rs_if.dispatch_qk_in}),
            rs_if.cdb_alu_h_in, rs_if.cdb_alu_result_in, rs_if.cdb_lsb_h_in, rs_if.cdb_lsb_result_in);
    end

    // Free the issued entry, place the dispatched one, and drop everything on a flush
    always_comb begin
        entries_d = woken;
        if (issue) entries_d[ready_idx].valid = 1'b0;
        if (dispatch_ok) entries_d[free_idx] = new_entry;
        if (rs_if.rob_rs_rst_in)
            for (int i = 0; i < RS_SIZE; i++) entries_d[i].valid = 1'b0;
    end

    // Issue register inputs: the selected entry, or a NOP bubble with zeroed fields
    always_comb begin
        opcode_d = issue ? woken[ready_idx].opcode : OP_NOP;
        vj_d     = issue ? woken[ready_idx].vj : '0;
        vk_d     = issue ? woken[ready_idx].vk : '0;
        a_d      = issue ? woken[ready_idx].a : '0;
        pc_d     = issue ? woken[ready_idx].pc : '0;
        dest_d   = issue ? woken[ready_idx].dest : '0;
    end

    // Entry and issue registers; rdy_in low freezes all of them, so CDB data that cycle is lost
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) entries_q[i] <= '0;
            opcode_q <= OP_NOP;
            vj_q     <= '0;
            vk_q     <= '0;
            a_q      <= '0;
            pc_q     <= '0;
            dest_q   <= '0;
        end else if (rs_if.rdy_in) begin
            entries_q <= entries_d;
            opcode_q  <= opcode_d;
            vj_q      <= vj_d;
            vk_q      <= vk_d;
            a_q       <= a_d;
            pc_q      <= pc_d;
            dest_q    <= dest_d;
        end
    end

    assign rs_if.rs_alu_opcode_out = opcode_q;
    assign rs_if.rs_alu_vj_out     = vj_q;
    assign rs_if.rs_alu_vk_out     = vk_q;
    assign rs_if.rs_alu_a_out      = a_q;
    assign rs_if.rs_alu_pc_out     = pc_q;
    assign rs_if.rs_alu_dest_out   = dest_q;
endmodule

// File: tb/tb_alu_reservation_station.sv
// tb_alu_reservation_station: directed self-checking bench for alu_reservation_station
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail = 0;

    alu_reservation_station_if bus();

    alu_reservation_station #(.RS_SIZE(16), .RS_IDX_W(4)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rs_if  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_issue(input string tag, input logic [5:0] op, input logic [31:0] vj,
                             input logic [31:0] vk, input logic [4:0] dest);
        chk({tag, ".opcode"}, 32'(bus.rs_alu_opcode_out), 32'(op));
        chk({tag, ".vj"}, bus.rs_alu_vj_out, vj);
        chk({tag, ".vk"}, bus.rs_alu_vk_out, vk);
        chk({tag, ".dest"}, 32'(bus.rs_alu_dest_out), 32'(dest));
    endtask

    task automatic chk_nop(input string tag);
        chk({tag, ".opcode"}, 32'(bus.rs_alu_opcode_out), 32'(OP_NOP));
        chk({tag, ".dest"}, 32'(bus.rs_alu_dest_out), 32'h0);
    endtask

    task automatic chk_full(input string tag, input logic exp);
        chk(tag, 32'(bus.rs_full_out), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] vj, input logic [4:0] qj,
                        input logic [31:0] vk, input logic [4:0] qk, input logic [4:0] dest);
        bus.dispatch_en_in     = 1'b1;
        bus.dispatch_opcode_in = op;
        bus.dispatch_vj_in     = vj;
        bus.dispatch_qj_in     = qj;
        bus.dispatch_vk_in     = vk;
        bus.dispatch_qk_in     = qk;
        bus.dispatch_a_in      = 32'h100 + 32'(dest);
        bus.dispatch_pc_in     = 32'h1000 + 32'(dest) * 4;
        bus.dispatch_dest_in   = dest;
    endtask

    task automatic idle();
        bus.dispatch_en_in = 1'b0;
    endtask

    task automatic cdb(input logic [4:0] ah, input logic [31:0] ar, input logic [4:0] lh, input logic [31:0] lr);
        bus.cdb_alu_h_in      = ah;
        bus.cdb_alu_result_in = ar;
        bus.cdb_lsb_h_in      = lh;
        bus.cdb_lsb_result_in = lr;
    endtask

    initial begin
        rst               = 1'b1;
        bus.rdy_in        = 1'b1;
        bus.rob_rs_rst_in = 1'b0;
        disp(OP_NOP, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        idle();
        cdb(5'd0, 32'h0, 5'd0, 32'h0);
        repeat (2) @(negedge clk);
        chk_nop("reset");
        chk("reset.vj", bus.rs_alu_vj_out, 32'h0);
        chk("reset.pc", bus.rs_alu_pc_out, 32'h0);
        chk_full("reset.full", 1'b0);
        rst = 1'b0;
        tick();
        chk_nop("post_reset");

        // Ready-at-dispatch ADD: write edge, then issue edge, then bubble
        disp(OP_ADD, 32'd5, 5'd0, 32'd7, 5'd0, 5'd3);
        tick();
        idle();
        chk_nop("add.write_edge");
        tick();
        chk_issue("add.issue", OP_ADD, 32'd5, 32'd7, 5'd3);
        chk("add.a", bus.rs_alu_a_out, 32'h103);
        chk("add.pc", bus.rs_alu_pc_out, 32'h100C);
        tick();
        chk_nop("add.after");

        // SUB waiting on tag 2, woken by the ALU bus one cycle after dispatch
        disp(OP_SUB, 32'd0, 5'd2, 32'd4, 5'd0, 5'd5);
        tick();
        idle();
        cdb(5'd2, 32'd9, 5'd0, 32'h0);
        chk_nop("sub.write_edge");
        tick();
        cdb(5'd0, 32'h0, 5'd0, 32'h0);
`ifndef ALU_RS_WAKEUP_BYPASS_EN
        chk_nop("sub.capture_edge");
        tick();
`endif
        chk_issue("sub.issue", OP_SUB, 32'd9, 32'd4, 5'd5);
        tick();
        chk_nop("sub.after");

        // Operand captured from the LSB bus in the dispatch cycle itself
        disp(OP_AND, 32'd3, 5'd0, 32'd0, 5'd6, 5'd7);
        cdb(5'd0, 32'h0, 5'd6, 32'hFFFF_FFFF);
        tick();
        idle();
        cdb(5'd0, 32'h0, 5'd0, 32'h0);
        chk_nop("and.write_edge");
        tick();
        chk_issue("and.issue", OP_AND, 32'd3, 32'hFFFF_FFFF, 5'd7);
        tick();
        chk_nop("and.after");

        // Fill all sixteen entries, drop a seventeenth, then drain in index order
        for (int i = 0; i < 16; i++) begin
            disp(OP_OR, 32'd0, 5'd4, 32'(i), 5'd0, 5'(i + 1));
            if (i == 15) chk_full("fill.not_full_at_15", 1'b0);
            tick();
        end
        chk_full("fill.full", 1'b1);
        chk_nop("fill.pending");
        disp(OP_ADD, 32'd0, 5'd0, 32'd0, 5'd0, 5'd31);
        tick();
        idle();
        chk_full("fill.drop.full", 1'b1);
        chk_nop("fill.drop.nop");
        cdb(5'd4, 32'h77, 5'd0, 32'h0);
        tick();
        cdb(5'd0, 32'h0, 5'd0, 32'h0);
`ifndef ALU_RS_WAKEUP_BYPASS_EN
        chk_nop("fill.capture_edge");
        chk_full("fill.capture_full", 1'b1);
        tick();
`endif
        for (int i = 0; i < 16; i++) begin
            chk_issue($sformatf("fill.issue%0d", i), OP_OR, 32'h77, 32'(i), 5'(i + 1));
            if (i == 0) chk_full("fill.freed", 1'b0);
            tick();
        end
        chk_nop("fill.drained");

        // Flush with five entries held (one ready) and a concurrent dispatch
        for (int i = 0; i < 4; i++) begin
            disp(OP_XOR, 32'd0, 5'd7, 32'd0, 5'd0, 5'(20 + i));
            tick();
        end
        disp(OP_SLL, 32'd1, 5'd0, 32'd2, 5'd0, 5'd19);
        tick();
        disp(OP_ADD, 32'd1, 5'd0, 32'd1, 5'd0, 5'd9);
        bus.rob_rs_rst_in = 1'b1;
        tick();
        bus.rob_rs_rst_in = 1'b0;
        idle();
        chk_nop("flush.edge");
        chk_full("flush.full", 1'b0);
        cdb(5'd7, 32'h55, 5'd0, 32'h0);
        tick();
        cdb(5'd0, 32'h0, 5'd0, 32'h0);
        chk_nop("flush.after1");
        tick();
        chk_nop("flush.after2");
        tick();
        chk_nop("flush.after3");

        // rdy_in low freezes entries and outputs and ignores dispatch
        disp(OP_ADD, 32'd1, 5'd0, 32'd2, 5'd0, 5'd4);
        tick();
        bus.rdy_in = 1'b0;
        disp(OP_ADD, 32'd8, 5'd0, 32'd8, 5'd0, 5'd8);
        tick();
        chk_nop("freeze.hold1");
        tick();
        chk_nop("freeze.hold2");
        bus.rdy_in = 1'b1;
        idle();
        tick();
        chk_issue("freeze.issue", OP_ADD, 32'd1, 32'd2, 5'd4);
        bus.rdy_in = 1'b0;
        tick();
        chk_issue("freeze.out_held", OP_ADD, 32'd1, 32'd2, 5'd4);
        bus.rdy_in = 1'b1;
        tick();
        chk_nop("freeze.no_dropped_dispatch");

        // A broadcast during a frozen cycle must not wake the entry
        disp(OP_SUB, 32'd0, 5'd3, 32'd8, 5'd0, 5'd13);
        tick();
        idle();
        bus.rdy_in = 1'b0;
        cdb(5'd3, 32'h99, 5'd0, 32'h0);
        tick();
        cdb(5'd0, 32'h0, 5'd0, 32'h0);
        bus.rdy_in = 1'b1;
        tick();
        chk_nop("freeze.cdb_ignored1");
        tick();
        chk_nop("freeze.cdb_ignored2");

        // Asynchronous reset in mid-cycle with ready entries in flight
        disp(OP_ADD, 32'h10, 5'd0, 32'd1, 5'd0, 5'd10);
        tick();
        disp(OP_ADD, 32'h11, 5'd0, 32'd1, 5'd0, 5'd11);
        tick();
        disp(OP_ADD, 32'h12, 5'd0, 32'd1, 5'd0, 5'd12);
        tick();
        idle();
        chk_issue("areset.before", OP_ADD, 32'h11, 32'd1, 5'd11);
        #2 rst = 1'b1;
        #1;
        chk_nop("areset.immediate");
        chk("areset.vj", bus.rs_alu_vj_out, 32'h0);
        chk_full("areset.full", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_nop("areset.first_edge");
        cdb(5'd3, 32'h99, 5'd0, 32'h0);
        tick();
        cdb(5'd0, 32'h0, 5'd0, 32'h0);
        chk_nop("areset.discarded1");
        tick();
        chk_nop("areset.discarded2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
